// File: rtl/barrier_speed_ctrl_if.sv
// Game-state <-> barrier-speed controller bundle.
// Master drives run/restart/frame_tick; slave returns speed, level and status.
interface barrier_speed_ctrl_if #(
  parameter int SPEED_W = 4,
  parameter int LEVEL_W = 4
);
  logic               restart;
  logic               run;
  logic               frame_tick;
  logic [SPEED_W-1:0] barrier_speed;
  logic [LEVEL_W-1:0] level;
  logic               level_up;
  logic               at_max;

  modport master (
    output restart, run, frame_tick,
    input  barrier_speed, level, level_up, at_max
  );

  modport slave (
    input  restart, run, frame_tick,
    output barrier_speed, level, level_up, at_max
  );
endinterface

// File: rtl/barrier_speed_ctrl.sv
// Barrier speed ramp: every TICKS_PER_STEP counted frame ticks speed += STEP, clamped at MAX_SPEED.
// Latency: speed/level/level_up/at_max update on the edge sampling the qualifying tick; no backpressure.
module barrier_speed_ctrl #(
  parameter int SPEED_W        = 4,
  parameter int INIT_SPEED     = 4,
  parameter int MAX_SPEED      = 12,
  parameter int STEP           = 1,
  parameter int TICKS_PER_STEP = 16,
  parameter int LEVEL_W        = 4
) (
  input logic                 clk,
  input logic                 rst,
  barrier_speed_ctrl_if.slave bus
);

  localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int SUM_W = SPEED_W + 1;

  localparam logic [SPEED_W-1:0] INIT_V      = SPEED_W'(INIT_SPEED);
  localparam logic [SPEED_W-1:0] MAX_V       = SPEED_W'(MAX_SPEED);
  localparam logic [SUM_W-1:0]   STEP_V      = SUM_W'(STEP);
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(TICKS_PER_STEP - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_SAT   = '1;
  localparam logic               INIT_AT_MAX = (INIT_SPEED == MAX_SPEED);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    MAXED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               level_up_q, level_up_d;
  logic               at_max_q, at_max_d;

  logic [SUM_W-1:0]   speed_sum;
  logic [SPEED_W-1:0] speed_bumped;

  // Extra carry bit keeps speed+STEP from wrapping below the ceiling.
  always_comb begin
    speed_sum    = {1'b0, speed_q} + STEP_V;
    speed_bumped = speed_sum[SPEED_W-1:0];
    if (speed_sum >= {1'b0, MAX_V}) begin
      speed_bumped = MAX_V;
    end
  end

  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    level_up_d = 1'b0;
    at_max_d   = at_max_q;

    if (bus.restart) begin
      state_d  = IDLE;
      speed_d  = INIT_V;
      level_d  = '0;
      cnt_d    = '0;
      at_max_d = INIT_AT_MAX;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.run) begin
            state_d = INIT_AT_MAX ? MAXED : RAMP;
          end
        end
        RAMP: begin
          if (bus.run && bus.frame_tick) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d      = '0;
              speed_d    = speed_bumped;
              level_d    = (level_q == LEVEL_SAT) ? level_q : level_q + LEVEL_W'(1);
              level_up_d = 1'b1;
              at_max_d   = (speed_bumped == MAX_V);
              if (speed_bumped == MAX_V) begin
                state_d = MAXED;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        MAXED: begin
          state_d = MAXED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      speed_q    <= INIT_V;
      level_q    <= '0;
      cnt_q      <= '0;
      level_up_q <= 1'b0;
      at_max_q   <= INIT_AT_MAX;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      level_up_q <= level_up_d;
      at_max_q   <= at_max_d;
    end
  end

  assign bus.barrier_speed = speed_q;
  assign bus.level         = level_q;
  assign bus.level_up      = level_up_q;
  assign bus.at_max        = at_max_q;

endmodule
